// File: rtl/processor_trace_buffer.sv
// processor_trace_buffer: cycle-stamped FIFO capture of ALU/MEM results with valid/ready drain.
module processor_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int STAMP_W = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Capture_En,
  input  logic                          Capture_Mode,
  input  logic [DATA_W-1:0]             ALU_Out,
  input  logic [DATA_W-1:0]             MEM_Out,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic [2*DATA_W+STAMP_W-1:0]   Out_Data,
  output logic [ADDR_W:0]               Count,
  output logic                          Full,
  output logic                          Empty,
  output logic                          Overflow,
  output logic [7:0]                    Drop_Cnt,
  input  logic                          Clear_Ovf
);
  localparam int EW = 2*DATA_W+STAMP_W;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_q, rd_q;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [STAMP_W-1:0]    stamp_q;
  logic [2*DATA_W-1:0]   last_q, cur;
  logic                  first_q, ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic                  cap, pop, push, drop;
  always_comb begin
    cur    = {MEM_Out, ALU_Out};
    Full   = cnt_q == (ADDR_W+1)'(DEPTH);
    Empty  = cnt_q == '0;
    pop    = !Empty & Out_Ready;
    cap    = Capture_En & (!Capture_Mode | !first_q | (cur != last_q));
    push   = cap & (!Full | pop);
    drop   = cap & Full & !pop;
    cnt_d  = (push & !pop) ? cnt_q + 1'b1 : (pop & !push) ? cnt_q - 1'b1 : cnt_q;
    // Clear takes priority over a same-cycle drop.
    ovf_d  = Clear_Ovf ? 1'b0 : ovf_q | drop;
    drop_d = Clear_Ovf ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      stamp_q <= '0;
      last_q  <= '0;
      first_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      stamp_q <= stamp_q + 1'b1;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (pop) rd_q <= rd_q + 1'b1;
      if (push) begin
        wr_q    <= wr_q + 1'b1;
        last_q  <= cur;
        first_q <= 1'b1;
      end
    end
  end
  // Storage needs no reset: reads are masked by Empty.
  always_ff @(posedge Clk) if (push) mem_q[wr_q] <= {stamp_q, cur};
  assign Out_Valid = !Empty;
  assign Out_Data  = Empty ? '0 : mem_q[rd_q];
  assign Count     = cnt_q;
  assign Overflow  = ovf_q;
  assign Drop_Cnt  = drop_q;
endmodule

// File: tb/tb_processor_trace_buffer.sv
// tb_processor_trace_buffer: directed stimulus with a scoreboard queue checked by a pop monitor.
module tb_processor_trace_buffer;
  localparam int DW = 32, SW = 16, EW = 2*DW+SW;
  logic Clk = 0, Reset = 0, Capture_En = 0, Capture_Mode = 0, Out_Ready = 0, Clear_Ovf = 0;
  logic [DW-1:0] ALU_Out = 0, MEM_Out = 0;
  logic Out_Valid, Full, Empty, Overflow;
  logic [EW-1:0] Out_Data;
  logic [4:0] Count;
  logic [7:0] Drop_Cnt;
  int checks = 0, errors = 0, edges = 0;
  logic [EW-1:0] sb[$];

  always #5 Clk = ~Clk;

  processor_trace_buffer dut (
    .Clk(Clk), .Reset(Reset), .Capture_En(Capture_En), .Capture_Mode(Capture_Mode),
    .ALU_Out(ALU_Out), .MEM_Out(MEM_Out), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Data(Out_Data), .Count(Count), .Full(Full), .Empty(Empty), .Overflow(Overflow),
    .Drop_Cnt(Drop_Cnt), .Clear_Ovf(Clear_Ovf)
  );

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  always @(negedge Clk) if (Reset && Out_Valid && Out_Ready) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL pop_unexpected: got %h expected no entry", Out_Data);
    end else chk("pop_data", Out_Data, sb.pop_front());
  end

  // Drives one cycle; exp_push is the hand-decided outcome, stamped with edges since reset.
  task automatic step(input logic en, input logic mode, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                      input logic rdy, input logic clr, input logic exp_push);
    Capture_En = en; Capture_Mode = mode; ALU_Out = alu; MEM_Out = mem; Out_Ready = rdy; Clear_Ovf = clr;
    if (exp_push) sb.push_back({SW'(edges), mem, alu});
    @(posedge Clk);
    #1;
    edges++;
  endtask

  task automatic reset_release();
    Capture_En = 0; Out_Ready = 0; Clear_Ovf = 0;
    @(posedge Clk);
    #1;
    Reset = 1;
    edges = 0;
  endtask

  initial begin
    // Test 1: reset state, then three captures drained in order
    #2;
    chk("rst_count", Count, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_valid", Out_Valid, 0);
    chk("rst_data", Out_Data, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_drop", Drop_Cnt, 0);
    reset_release();
    step(1, 0, 5, 32'hA, 0, 0, 1);
    chk("t1_latency_count", Count, 1);
    step(1, 0, 6, 32'hA, 0, 0, 1);
    step(1, 0, 7, 32'hA, 0, 0, 1);
    chk("t1_count", Count, 3);
    chk("t1_head", Out_Data, {16'd0, 32'hA, 32'd5});
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("t1_empty", Empty, 1);
    chk("t1_sb_drained", sb.size(), 0);

    // Test 2: change-only mode
    Reset = 0;
    #1;
    reset_release();
    for (int i = 0; i < 4; i++) step(1, 1, 9, 0, 0, 0, i == 0);
    step(1, 1, 10, 0, 0, 0, 1);
    chk("t2_count", Count, 2);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t2_second_head", Out_Data, {16'd4, 32'd0, 32'd10});
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t2_empty", Empty, 1);

    // Test 3: fill, overflow, saturation, clear
    Reset = 0;
    #1;
    reset_release();
    for (int i = 0; i < 16; i++) step(1, 0, i, 32'h100 + i, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 77, 77, 0, 0, 0);
    chk("t3_full", Full, 1);
    chk("t3_count", Count, 16);
    chk("t3_ovf", Overflow, 1);
    chk("t3_drop3", Drop_Cnt, 3);
    for (int i = 0; i < 255; i++) step(1, 0, 78, 78, 0, 0, 0);
    chk("t3_drop_sat", Drop_Cnt, 255);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t3_clr_ovf", Overflow, 0);
    chk("t3_clr_drop", Drop_Cnt, 0);
    chk("t3_intact_count", Count, 16);
    chk("t3_intact_head", Out_Data, {16'd0, 32'h100, 32'd0});
    step(1, 0, 79, 79, 0, 1, 0);
    chk("t3_clr_wins_ovf", Overflow, 0);
    chk("t3_clr_wins_drop", Drop_Cnt, 0);

    // Test 4: full with simultaneous push and pop, pointers wrap
    for (int k = 0; k < 20; k++) step(1, 0, 100 + k, 32'h55, 1, 0, 1);
    chk("t4_count", Count, 16);
    chk("t4_drop", Drop_Cnt, 0);
    chk("t4_ovf", Overflow, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("t4_count5", Count, 5);

    // Test 5: reset mid-drain, then first capture accepted despite equal data
    #2;
    Reset = 0;
    #1;
    chk("t5_count", Count, 0);
    chk("t5_empty", Empty, 1);
    chk("t5_valid", Out_Valid, 0);
    chk("t5_data", Out_Data, 0);
    sb.delete();
    @(posedge Clk);
    #1;
    reset_release();
    step(1, 1, 119, 32'h55, 0, 0, 1);
    chk("t5_first_count", Count, 1);
    chk("t5_first_head", Out_Data, {16'd0, 32'h55, 32'd119});
    step(1, 1, 119, 32'h55, 0, 0, 0);
    chk("t5_repeat_suppressed", Count, 1);
    step(0, 0, 0, 0, 1, 0, 0);

    // Test 6: stamp wrap with sparse captures
    for (int i = 0; i < 65540; i++) begin
      logic en;
      en = (edges % 8192 == 7) || edges == 65535 || edges == 65536;
      step(en, 0, edges, ~edges, 1, 0, en);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t6_empty", Empty, 1);
    chk("t6_drop", Drop_Cnt, 0);
    chk("t6_ovf", Overflow, 0);
    chk("t6_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
